// File: rtl/coin_pulse_sched.sv
// Coin pulse scheduler: queues single-cycle coin pulses from the two key
// filters and replays them one at a time to the vending FSM, with a fixed
// idle gap after each issued coin and issue held off while the FSM is busy.
module coin_pulse_sched #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned GAP_CYC = 50000
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst_n,
    input  logic                       coin_half_in,
    input  logic                       coin_one_in,
    input  logic                       vend_busy,
    input  logic                       ovf_clr,
    output logic                       po_half,
    output logic                       po_one,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level,
    output logic                       overflow
);

    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(GAP_CYC + 1);

    localparam logic [LW:0]   DEPTH_V  = DEPTH[LW:0];
    localparam logic [LW:0]   ONE_V    = {{LW{1'b0}}, 1'b1};
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYC - 1);

    typedef enum logic {
        IDLE,
        GAP
    } state_t;

    state_t          state;
    logic [DEPTH-1:0] mem;        // 0 = half coin, 1 = one coin
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   gap_cnt;

    logic            pop;
    logic [LW:0]     free_slots;
    logic            acc_half;
    logic            acc_one;
    logic            drop;
    logic [PW-1:0]   wr_ptr_one;

    // Issue decision and push acceptance; a pop this cycle frees one slot
    always_comb begin
        pop        = (state == IDLE) && (fifo_level != '0) && !vend_busy;
        free_slots = DEPTH_V - {1'b0, fifo_level} + {{LW{1'b0}}, pop};
        acc_half   = coin_half_in && (free_slots != '0);
        acc_one    = coin_one_in &&
                     (acc_half ? (free_slots > ONE_V) : (free_slots != '0));
        drop       = (coin_half_in && !acc_half) || (coin_one_in && !acc_one);
        // half goes first when both arrive, so one lands in the next slot
        wr_ptr_one = acc_half ? (wr_ptr + PW'(1)) : wr_ptr;
    end

    // Queue storage, write pointer, occupancy and sticky overflow
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mem        <= '0;
            wr_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
        end else begin
            if (acc_half) mem[wr_ptr]     <= 1'b0;
            if (acc_one)  mem[wr_ptr_one] <= 1'b1;
            wr_ptr     <= wr_ptr_one + PW'(acc_one);
            fifo_level <= fifo_level + LW'(acc_half) + LW'(acc_one) - LW'(pop);
            if (drop)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

    // Issue FSM: pop head in IDLE, then hold GAP for GAP_CYC cycles
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state   <= IDLE;
            rd_ptr  <= '0;
            gap_cnt <= '0;
            po_half <= 1'b0;
            po_one  <= 1'b0;
        end else begin
            po_half <= 1'b0;
            po_one  <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        po_half <= !mem[rd_ptr];
                        po_one  <= mem[rd_ptr];
                        rd_ptr  <= rd_ptr + PW'(1);
                        gap_cnt <= GAP_LOAD;
                        state   <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt == '0)
                        state <= IDLE;
                    else
                        gap_cnt <= gap_cnt - CW'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_coin_pulse_sched.sv
// Directed bench for coin_pulse_sched with DEPTH=4, GAP_CYC=4.
module tb_coin_pulse_sched;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic       coin_half_in;
    logic       coin_one_in;
    logic       vend_busy;
    logic       ovf_clr;
    logic       po_half;
    logic       po_one;
    logic [2:0] fifo_level;
    logic       overflow;

    int compared   = 0;
    int mismatched = 0;

    coin_pulse_sched #(.DEPTH(4), .GAP_CYC(4)) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .coin_half_in (coin_half_in),
        .coin_one_in  (coin_one_in),
        .vend_busy    (vend_busy),
        .ovf_clr      (ovf_clr),
        .po_half      (po_half),
        .po_one       (po_one),
        .fifo_level   (fifo_level),
        .overflow     (overflow)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic h, o, b, c;
        logic ph, p1;
        int   lvl;
        logic ovf;
    } vec_t;

    vec_t vecs[$];

    // issue monitor state
    logic mon_en  = 1'b0;
    int   cyc     = 0;
    int   last_cyc = -1;
    int   issued  = 0;
    logic exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic e;
        if (po_half && po_one)
            check("t6_both_high", 1, 0);
        if (po_half || po_one) begin
            if (last_cyc >= 0) begin
                compared++;
                if (cyc - last_cyc < 5) begin
                    mismatched++;
                    $display("FAIL t6_gap actual=%0d required>=5", cyc - last_cyc);
                end
            end
            if (exp_q.size() == 0) begin
                check("t6_unexpected_issue", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("t6_order%0d", issued), int'(po_one), int'(e));
            end
            last_cyc = cyc;
            issued++;
        end
    endtask

    task automatic step(input logic h, input logic o, input logic b, input logic c);
        coin_half_in = h;
        coin_one_in  = o;
        vend_busy    = b;
        ovf_clr      = c;
        @(posedge sys_clk);
        #1;
        cyc++;
        if (mon_en) monitor();
    endtask

    function automatic void add(input logic h, input logic o, input logic b, input logic c,
                                input logic ph, input logic p1, input int lvl, input logic ovf);
        vec_t v;
        v.h = h; v.o = o; v.b = b; v.c = c;
        v.ph = ph; v.p1 = p1; v.lvl = lvl; v.ovf = ovf;
        vecs.push_back(v);
    endfunction

    function automatic void addn(input int n, input int lvl, input logic ovf);
        for (int i = 0; i < n; i++) add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, lvl, ovf);
    endfunction

    initial begin
        int   pulses;
        logic [9:0] pat;

        sys_rst_n    = 1'b0;
        coin_half_in = 1'b0;
        coin_one_in  = 1'b0;
        vend_busy    = 1'b0;
        ovf_clr      = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_po_half", int'(po_half), 0);
        check("rst_po_one", int'(po_one), 0);
        check("rst_level", int'(fifo_level), 0);
        check("rst_overflow", int'(overflow), 0);
        sys_rst_n = 1'b1;

        // test 1: single half
        add(1,0,0,0, 0,0,1,0);
        add(0,0,0,0, 1,0,0,0);
        addn(4, 0, 0);
        // test 2: half+one together, half first, one 5 cycles later
        add(1,1,0,0, 0,0,2,0);
        add(0,0,0,0, 1,0,1,0);
        addn(4, 1, 0);
        add(0,0,0,0, 0,1,0,0);
        addn(4, 0, 0);
        // test 3: busy, 5 one pulses saturate and overflow
        for (int i = 1; i <= 4; i++) add(0,1,1,0, 0,0,i,0);
        add(0,1,1,0, 0,0,4,1);
        add(0,0,1,0, 0,0,4,1);
        add(0,0,0,0, 0,1,3,1);
        addn(4, 3, 1);
        add(0,0,0,0, 0,1,2,1);
        addn(4, 2, 1);
        add(0,0,0,0, 0,1,1,1);
        addn(4, 1, 1);
        add(0,0,0,0, 0,1,0,1);
        add(0,0,0,1, 0,0,0,0);
        addn(3, 0, 0);
        // test 4: level 3 with pop accepts both; without pop drops one
        add(1,0,1,0, 0,0,1,0);
        add(1,0,1,0, 0,0,2,0);
        add(1,0,1,0, 0,0,3,0);
        add(1,1,0,0, 1,0,4,0);
        addn(3, 4, 0);
        add(0,0,1,0, 0,0,4,0);
        add(0,0,0,0, 1,0,3,0);
        add(1,1,0,1, 0,0,4,1);   // drop beats clear
        add(0,0,0,1, 0,0,4,0);
        addn(2, 4, 0);
        add(0,0,0,0, 1,0,3,0);
        addn(4, 3, 0);
        add(0,0,0,0, 1,0,2,0);
        addn(4, 2, 0);
        add(0,0,0,0, 0,1,1,0);
        addn(4, 1, 0);
        add(0,0,0,0, 1,0,0,0);
        addn(4, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].h, vecs[i].o, vecs[i].b, vecs[i].c);
            check($sformatf("v%0d_po_half", i), int'(po_half), int'(vecs[i].ph));
            check($sformatf("v%0d_po_one", i), int'(po_one), int'(vecs[i].p1));
            check($sformatf("v%0d_level", i), int'(fifo_level), vecs[i].lvl);
            check($sformatf("v%0d_overflow", i), int'(overflow), int'(vecs[i].ovf));
        end

        // test 5: reset asserted while first of two coins is issuing
        step(1, 1, 0, 0);
        step(0, 0, 0, 0);
        check("t5_po_half_before_rst", int'(po_half), 1);
        check("t5_level_before_rst", int'(fifo_level), 1);
        #2 sys_rst_n = 1'b0;
        #1;
        check("t5_rst_po_half", int'(po_half), 0);
        check("t5_rst_po_one", int'(po_one), 0);
        check("t5_rst_level", int'(fifo_level), 0);
        check("t5_rst_overflow", int'(overflow), 0);
        @(posedge sys_clk);
        #1 sys_rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0, 0);
            if (po_half || po_one) pulses++;
        end
        check("t5_no_issue_after_rst", pulses, 0);
        check("t5_level_after_rst", int'(fifo_level), 0);

        // test 6: ten coins with busy toggling, order and spacing preserved
        pat    = 10'b0110100111;
        mon_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(pat[i]);
            step(!pat[i], pat[i], (i % 3) == 0, 1'b0);
            for (int j = 1; j < 8; j++) step(1'b0, 1'b0, ((i + j) % 3) == 0, 1'b0);
        end
        for (int k = 0; k < 300 && issued < 10; k++) step(0, 0, 0, 0);
        check("t6_issued", issued, 10);
        check("t6_overflow", int'(overflow), 0);
        check("t6_level", int'(fifo_level), 0);
        mon_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
